// File: rtl/pc_sequencer_if.sv
// Control/stack bundle between the decode stage (master) and the program-counter
// sequencer (slave).
interface pc_sequencer_if #(
    parameter int unsigned WIDTH = 10,
    parameter int unsigned DEPTH = 16
);
    localparam int unsigned DW = $clog2(DEPTH) + 1;

    logic             jump;
    logic             branch;
    logic             zero;
    logic             jal;
    logic             ret;
    logic             reti;
    logic [WIDTH-1:0] target;
    logic [WIDTH-1:0] stack_top;
    logic             irq;
    logic             irq_en;
    logic [WIDTH-1:0] pc;
    logic             stack_push;
    logic             stack_pop;
    logic [WIDTH-1:0] stack_data;
    logic [DW-1:0]    depth;
    logic             in_isr;
    logic             fault;

    modport master (
        output jump, branch, zero, jal, ret, reti, target, stack_top, irq, irq_en,
        input  pc, stack_push, stack_pop, stack_data, depth, in_isr, fault
    );

    modport slave (
        input  jump, branch, zero, jal, ret, reti, target, stack_top, irq, irq_en,
        output pc, stack_push, stack_pop, stack_data, depth, in_isr, fault
    );
endinterface

// File: rtl/pc_sequencer.sv
// Program counter / next-address unit with call-depth tracking for a return-address
// stack; any stack overflow or underflow parks the sequencer in a sticky FAULT state.
module pc_sequencer #(
    parameter int unsigned      WIDTH     = 10,
    parameter int unsigned      DEPTH     = 16,
    parameter logic [WIDTH-1:0] RESET_VEC = '0,
    parameter logic [WIDTH-1:0] IRQ_VEC   = WIDTH'(10'h3FC)
) (
    input logic           clk,
    input logic           reset,
    pc_sequencer_if.slave bus
);
    localparam int unsigned DW = $clog2(DEPTH) + 1;

    localparam logic [0:0] RUN   = 1'b0;
    localparam logic [0:0] FAULT = 1'b1;

    logic [0:0]       state_q;
    logic [WIDTH-1:0] pc_q;
    logic [DW-1:0]    depth_q;
    logic             in_isr_q;

    logic             run;
    logic             irq_take;
    logic             any_ret;
    logic             do_ret;
    logic             do_jal;
    logic             do_tgt;
    logic             full;
    logic             empty;
    logic             overflow;
    logic             underflow;
    logic             push_ok;
    logic             pop_ok;
    logic [WIDTH-1:0] pc_inc;
    logic [WIDTH-1:0] pc_next;

    // One decision per cycle; each lower-priority control is masked by all higher ones.
    always_comb begin
        run       = (state_q == RUN);
        any_ret   = bus.ret | bus.reti;
        irq_take  = run & bus.irq & bus.irq_en & ~in_isr_q;
        do_ret    = run & ~irq_take & any_ret;
        do_jal    = run & ~irq_take & ~any_ret & bus.jal;
        do_tgt    = run & ~irq_take & ~any_ret & ~bus.jal & (bus.jump | (bus.branch & bus.zero));
        full      = (depth_q == DW'(DEPTH));
        empty     = (depth_q == '0);
        overflow  = (irq_take | do_jal) & full;
        underflow = do_ret & empty;
        push_ok   = (irq_take | do_jal) & ~full;
        pop_ok    = do_ret & ~empty;
        pc_inc    = pc_q + WIDTH'(1);

        pc_next = pc_inc;
        if (irq_take)
            pc_next = IRQ_VEC;
        else if (do_ret)
            pc_next = bus.stack_top;
        else if (do_jal || do_tgt)
            pc_next = bus.target;

        bus.stack_push = push_ok & ~reset;
        bus.stack_pop  = pop_ok & ~reset;
        // Interrupt entry returns to the interrupted instruction, a call to the next one.
        bus.stack_data = irq_take ? pc_q : pc_inc;
        bus.pc         = pc_q;
        bus.depth      = depth_q;
        bus.in_isr     = in_isr_q;
        bus.fault      = (state_q == FAULT);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= RUN;
            pc_q     <= RESET_VEC;
            depth_q  <= '0;
            in_isr_q <= 1'b0;
        end else if (state_q == RUN) begin
            if (overflow || underflow) begin
                state_q <= FAULT;
            end else begin
                pc_q <= pc_next;
                if (push_ok)
                    depth_q <= depth_q + DW'(1);
                else if (pop_ok)
                    depth_q <= depth_q - DW'(1);
                if (irq_take)
                    in_isr_q <= 1'b1;
                else if (do_ret && bus.reti)
                    in_isr_q <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: a cycle model checks every output on each falling
// edge, and literal expectations at key points pin the model.
module tb_pc_sequencer;
    localparam int unsigned WIDTH = 10;
    localparam int unsigned DEPTH = 16;

    logic clk = 1'b0;
    logic reset;
    int   vectors = 0;
    int   miscompares = 0;

    pc_sequencer_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

    pc_sequencer #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .RESET_VEC(10'h000), .IRQ_VEC(10'h3FC)
    ) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: architectural state plus an explicit return-address count.
    bit model_valid = 0;
    int m_pc, m_depth;
    bit m_isr, m_fault;

    initial begin
        forever begin
            int  npc, edata;
            bit  epush, epop, nisr, nfault;
            int  ndepth;
            @(negedge clk);
            epush = 0; epop = 0; edata = 0;
            npc = (m_pc + 1) % 1024; ndepth = m_depth; nisr = m_isr; nfault = m_fault;
            if (!reset && model_valid && !m_fault) begin
                if (bus.irq && bus.irq_en && !m_isr) begin
                    if (m_depth == DEPTH) nfault = 1;
                    else begin epush = 1; edata = m_pc; npc = 'h3FC; nisr = 1; ndepth++; end
                end else if (bus.ret || bus.reti) begin
                    if (m_depth == 0) nfault = 1;
                    else begin epop = 1; npc = bus.stack_top; ndepth--; if (bus.reti) nisr = 0; end
                end else if (bus.jal) begin
                    if (m_depth == DEPTH) nfault = 1;
                    else begin epush = 1; edata = (m_pc + 1) % 1024; npc = bus.target; ndepth++; end
                end else if (bus.jump || (bus.branch && bus.zero)) begin
                    npc = bus.target;
                end
                if (nfault) npc = m_pc;
            end else if (!reset && model_valid) begin
                npc = m_pc;
            end
            if (model_valid) begin
                chk("pc", int'(bus.pc), m_pc);
                chk("depth", int'(bus.depth), m_depth);
                chk("in_isr", int'(bus.in_isr), int'(m_isr));
                chk("fault", int'(bus.fault), int'(m_fault));
                chk("stack_push", int'(bus.stack_push), int'(epush));
                chk("stack_pop", int'(bus.stack_pop), int'(epop));
                if (epush) chk("stack_data", int'(bus.stack_data), edata);
            end
            if (reset) begin
                m_pc = 0; m_depth = 0; m_isr = 0; m_fault = 0; model_valid = 1;
            end else if (model_valid) begin
                m_pc = npc; m_depth = ndepth; m_isr = nisr; m_fault = nfault;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        bus.jump = 0; bus.branch = 0; bus.zero = 0; bus.jal = 0; bus.ret = 0; bus.reti = 0;
        bus.target = '0; bus.stack_top = '0; bus.irq = 0; bus.irq_en = 0;
    endtask

    task automatic do_reset();
        reset = 1; tick(); reset = 0;
    endtask

    task automatic go_to(input logic [9:0] a);
        bus.jump = 1; bus.target = a; tick(); clr();
        chk("goto_pc", int'(bus.pc), int'(a));
    endtask

    initial begin
        clr();
        reset = 1;
        tick();
        do_reset();

        // 1: idle increment from reset vector
        chk("reset_pc", int'(bus.pc), 0);
        chk("reset_depth", int'(bus.depth), 0);
        for (int i = 1; i <= 5; i++) begin
            tick();
            chk("idle_pc", int'(bus.pc), i);
        end

        // 2: call, body, return
        go_to(10'h010);
        bus.jal = 1; bus.target = 10'h100; #1;
        chk("jal_push", int'(bus.stack_push), 1);
        chk("jal_data", int'(bus.stack_data), 'h011);
        tick(); clr();
        chk("jal_pc", int'(bus.pc), 'h100);
        chk("jal_depth", int'(bus.depth), 1);
        tick(); tick(); tick();
        chk("body_pc", int'(bus.pc), 'h103);
        bus.ret = 1; bus.stack_top = 10'h011; #1;
        chk("ret_pop", int'(bus.stack_pop), 1);
        tick(); clr();
        chk("ret_pc", int'(bus.pc), 'h011);
        chk("ret_depth", int'(bus.depth), 0);

        // 3: branch not taken / taken
        go_to(10'h020);
        bus.branch = 1; bus.zero = 0; bus.target = 10'h050; tick();
        chk("br_nt_pc", int'(bus.pc), 'h021);
        bus.zero = 1; tick(); clr();
        chk("br_t_pc", int'(bus.pc), 'h050);

        // 4: interrupt beats jal, no nesting, reti
        go_to(10'h030);
        bus.irq = 1; bus.irq_en = 1; bus.jal = 1; bus.target = 10'h100; #1;
        chk("irq_push", int'(bus.stack_push), 1);
        chk("irq_data", int'(bus.stack_data), 'h030);
        tick();
        chk("irq_pc", int'(bus.pc), 'h3FC);
        chk("irq_isr", int'(bus.in_isr), 1);
        bus.jal = 0; tick();
        chk("irq_nest_pc", int'(bus.pc), 'h3FD);
        chk("irq_nest_depth", int'(bus.depth), 1);
        bus.irq = 0; bus.reti = 1; bus.stack_top = 10'h030; tick(); clr();
        chk("reti_pc", int'(bus.pc), 'h030);
        chk("reti_isr", int'(bus.in_isr), 0);

        // 5: overflow on the 17th call, then underflow
        do_reset();
        for (int i = 0; i < 16; i++) begin
            bus.jal = 1; bus.target = 10'(10'h200 + i); tick();
        end
        chk("full_depth", int'(bus.depth), 16);
        chk("full_pc", int'(bus.pc), 'h20F);
        bus.target = 10'h300; #1;
        chk("ovf_push", int'(bus.stack_push), 0);
        tick(); clr();
        chk("ovf_fault", int'(bus.fault), 1);
        tick(); tick(); tick();
        chk("ovf_frozen_pc", int'(bus.pc), 'h20F);
        chk("ovf_depth", int'(bus.depth), 16);
        do_reset();
        chk("fault_cleared", int'(bus.fault), 0);
        bus.ret = 1; bus.stack_top = 10'h155; #1;
        chk("unf_pop", int'(bus.stack_pop), 0);
        tick(); clr();
        chk("unf_fault", int'(bus.fault), 1);
        chk("unf_pc", int'(bus.pc), 0);
        do_reset();

        // 6: wraparound and reset overriding a call
        go_to(10'h3FF);
        tick();
        chk("wrap_pc", int'(bus.pc), 0);
        go_to(10'h040);
        bus.jal = 1; bus.target = 10'h100; tick();
        chk("pre_rst_depth", int'(bus.depth), 1);
        reset = 1; #1;
        chk("rst_push", int'(bus.stack_push), 0);
        tick(); reset = 0; clr();
        chk("rst_pc", int'(bus.pc), 0);
        chk("rst_depth", int'(bus.depth), 0);
        tick(); tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
Program-counter and next-address unit feeding the processor's 16-entry return-address stack.
- Holds the PC and selects the next PC from: increment, jump, conditional branch, call (jal), return (ret/reti) and interrupt entry.
- Generates the stack push/pop strobes and the return address to push.
- Tracks call depth, detects stack overflow/underflow, and halts in a fault state.

Parameters:
WIDTH, 10, PC / address width (matches stack data width)
DEPTH, 16, stack capacity in entries
RESET_VEC, 0, PC value after reset
IRQ_VEC, 10'h3FC, interrupt entry address

Ports:
clk  input  1  clock, all state on rising edge
reset  input  1  synchronous, active-high
jump  input  1  unconditional jump to target
branch  input  1  conditional branch, taken when zero=1
zero  input  1  ALU zero flag
jal  input  1  call: push PC+1, go to target
ret  input  1  return: pop, go to stack_top
reti  input  1  return from interrupt: as ret, also clears in_isr
target  input  WIDTH  jump/branch/call destination
stack_top  input  WIDTH  stack read data (current top entry, combinational)
irq  input  1  interrupt request, level
irq_en  input  1  global interrupt enable
pc  output  WIDTH  current instruction address
stack_push  output  1  stack write strobe (push this cycle)
stack_pop  output  1  stack pop strobe
stack_data  output  WIDTH  address to push
depth  output  clog2(DEPTH)+1  current stack occupancy
in_isr  output  1  servicing interrupt
fault  output  1  stack overflow/underflow occurred; sticky

Behaviour:
- Reset (synchronous, highest priority): pc=RESET_VEC, depth=0, in_isr=0, fault=0, state=RUN. Strobes are 0 in the reset cycle.
- States:
  - RUN: normal sequencing.
  - FAULT: pc held, strobes 0, depth held, fault=1. Only reset exits FAULT.
- Next-PC priority in RUN, one decision per cycle, PC register updates at the clock edge (latency 1):
  1. Interrupt taken (irq & irq_en & ~in_isr): push pc (current, not +1; the interrupted instruction re-executes), pc<=IRQ_VEC, in_isr<=1. All instruction controls are ignored that cycle.
  2. ret or reti: pop, pc<=stack_top. reti also sets in_isr<=0.
  3. jal: push pc+1, pc<=target.
  4. jump: pc<=target.
  5. branch & zero: pc<=target. A branch that is not taken falls through to increment.
  6. Otherwise pc<=pc+1.
- Arithmetic: pc+1 is modulo 2^WIDTH; 10'h3FF increments to 10'h000 with no flag.
- Strobes are combinational from the current state and inputs, asserted for exactly the decision cycle.
  - Push: stack_data = address to push; stack writes on the same edge.
  - Pop: stack_top must be valid in that cycle (combinational read); stack pointer decrements on the edge.
- Depth counter: +1 on push, -1 on pop, never both in one cycle.
- Overflow: a push requested when depth==DEPTH.
  - Push suppressed; pc, depth and in_isr unchanged; enter FAULT next edge.
- Underflow: a pop requested when depth==0.
  - Pop suppressed; nothing else changes; enter FAULT.
- An interrupt that would overflow also faults; in_isr stays 0.
- More than one instruction control in a cycle: resolved by the priority above. Not illegal, no fault.
- irq while in_isr=1: ignored (no nesting) until reti.
- Reset mid-operation: reset in any cycle overrides every strobe. The stack module's own reset clears its pointer on the same edge.

Test Plan:
1. Reset then 5 idle cycles -> pc 0,1,2,3,4,5; no strobes; depth 0.
2. At pc=0x010, jal target=0x100, then 3 increments, then ret with stack_top=0x011 -> push data 0x011; pc 0x100..0x103, then 0x011; depth 1 then 0.
3. At pc=0x020, branch zero=0 -> 0x021; at 0x021, branch zero=1 target=0x050 -> 0x050.
4. Interrupt: irq=1, irq_en=1 at pc=0x030 with jal also asserted -> push 0x030, pc=0x3FC, in_isr=1, jal ignored. A second irq is ignored. reti with stack_top=0x030 -> pc=0x030, in_isr=0.
5. 16 nested jal calls then a 17th -> depth reaches 16; the 17th gives no push, fault=1, pc frozen until reset. Separately: ret at depth 0 -> fault=1, stack_pop=0.
6. pc=0x3FF with no control asserted -> pc=0x000 next cycle. Reset asserted during a jal cycle -> pc=0, no push, depth=0.
